// File: rtl/updown_count_decoder.sv
// Decoder/checker for an up/down counter: recovers direction from q, flags bad steps and L values.
// Optional: define UPDOWN_DEC_DIRCHG_ERR_EN to treat a direction reversal in LOCKED as a step error.
module updown_count_decoder #(
   parameter int WIDTH    = 2,
   parameter int ERRCNT_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WIDTH-1:0]    q_in,
   input  logic                l_in,
   input  logic                clr,
   output logic                dir,
   output logic                dir_valid,
   output logic                step_err,
   output logic                l_err,
   output logic                err_sticky,
   output logic [ERRCNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      PRIMED = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    q_prev_q, q_prev_d;
   logic                dir_q, dir_d;
   logic                dir_valid_q, dir_valid_d;
   logic                step_err_q, step_err_d;
   logic                l_err_q, l_err_d;
   logic                err_sticky_q, err_sticky_d;
   logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [WIDTH-1:0]    delta;
   logic                step_up, step_dn, step_hold;
   logic                l_exp, err_event;

   // Modular difference makes the wrap steps (max->0, 0->max) look like ordinary +-1 steps.
   always_comb begin
      delta     = q_in - q_prev_q;
      step_up   = (delta == {{(WIDTH-1){1'b0}}, 1'b1});
      step_dn   = (delta == {WIDTH{1'b1}});
      step_hold = (delta == '0);
   end

   always_comb begin
      state_d      = state_q;
      q_prev_d     = q_in;
      dir_d        = dir_q;
      dir_valid_d  = dir_valid_q;
      step_err_d   = 1'b0;
      l_err_d      = 1'b0;
      err_sticky_d = err_sticky_q;
      err_cnt_d    = err_cnt_q;
      l_exp        = 1'b0;
      err_event    = 1'b0;

      case (state_q)
         EMPTY: begin
            state_d = PRIMED;
         end
         PRIMED: begin
            if (step_up || step_dn) begin
               dir_d       = step_up;
               dir_valid_d = 1'b1;
               state_d     = LOCKED;
            end else if (!step_hold) begin
               step_err_d = 1'b1;
            end
         end
         LOCKED: begin
            if (step_up || step_dn) begin
`ifdef UPDOWN_DEC_DIRCHG_ERR_EN
               if (step_up != dir_q) step_err_d = 1'b1;
`endif
               dir_d = step_up;
            end else if (!step_hold) begin
               step_err_d = 1'b1;
            end
            // L is judged against the direction after this sample's update.
            l_exp   = dir_d ? (q_in == {WIDTH{1'b1}}) : (q_in == '0);
            l_err_d = (l_in != l_exp);
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      // A simultaneous step and L fault is a single event; an error beats clr.
      err_event = step_err_d | l_err_d;
      if (clr) begin
         err_sticky_d = 1'b0;
         err_cnt_d    = '0;
      end
      if (err_event) begin
         err_sticky_d = 1'b1;
         if (clr)
            err_cnt_d = ERRCNT_W'(1);
         else if (err_cnt_q != {ERRCNT_W{1'b1}})
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= EMPTY;
         q_prev_q     <= '0;
         dir_q        <= 1'b0;
         dir_valid_q  <= 1'b0;
         step_err_q   <= 1'b0;
         l_err_q      <= 1'b0;
         err_sticky_q <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         q_prev_q     <= q_prev_d;
         dir_q        <= dir_d;
         dir_valid_q  <= dir_valid_d;
         step_err_q   <= step_err_d;
         l_err_q      <= l_err_d;
         err_sticky_q <= err_sticky_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign dir        = dir_q;
   assign dir_valid  = dir_valid_q;
   assign step_err   = step_err_q;
   assign l_err      = l_err_q;
   assign err_sticky = err_sticky_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_updown_count_decoder.sv
// Directed bench for updown_count_decoder (WIDTH=2, ERRCNT_W=4).
// Observed word layout: {dir, dir_valid, step_err, l_err, err_sticky, err_cnt[3:0]}.
module tb_updown_count_decoder;

   logic       clk;
   logic       reset;
   logic [1:0] q_in;
   logic       l_in;
   logic       clr;
   logic       dir, dir_valid, step_err, l_err, err_sticky;
   logic [3:0] err_cnt;
   logic [8:0] obs;

   int checks = 0;
   int errors = 0;

   updown_count_decoder #(.WIDTH(2), .ERRCNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .q_in       (q_in),
      .l_in       (l_in),
      .clr        (clr),
      .dir        (dir),
      .dir_valid  (dir_valid),
      .step_err   (step_err),
      .l_err      (l_err),
      .err_sticky (err_sticky),
      .err_cnt    (err_cnt)
   );

   assign obs = {dir, dir_valid, step_err, l_err, err_sticky, err_cnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one sample, let the edge take it, then sample just after the edge.
   task automatic apply(input logic [1:0] q, input logic l, input logic c);
      q_in = q;
      l_in = l;
      clr  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      q_in = 2'd2; l_in = 1'b1; clr = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== 9'b0) begin
         errors++;
         $display("FAIL reset_state: got %b expected %b", obs, 9'b0);
      end
      reset = 1'b1;
   endtask

   task automatic test_count_up();
      logic [1:0] qv [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic       lv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [8:0] ev [5] = '{9'b0_0_0_0_0_0000, 9'b1_1_0_0_0_0000, 9'b1_1_0_0_0_0000,
                             9'b1_1_0_0_0_0000, 9'b1_1_0_0_0_0000};
      for (int i = 0; i < 5; i++) begin
         apply(qv[i], lv[i], 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++;
            $display("FAIL count_up[%0d]: got %b expected %b", i, obs, ev[i]);
         end
      end
   endtask

   task automatic test_count_down();
      logic [1:0] qv [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
      logic       lv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [8:0] ev [5] = '{9'b0_0_0_0_0_0000, 9'b0_1_0_0_0_0000, 9'b0_1_0_0_0_0000,
                             9'b0_1_0_0_0_0000, 9'b0_1_0_0_0_0000};
      hold_reset();
      for (int i = 0; i < 5; i++) begin
         apply(qv[i], lv[i], 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++;
            $display("FAIL count_down[%0d]: got %b expected %b", i, obs, ev[i]);
         end
      end
   endtask

   task automatic test_illegal_step();
      logic [1:0] qv [4] = '{2'd0, 2'd1, 2'd3, 2'd3};
      logic       lv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [8:0] ev [4] = '{9'b0_0_0_0_0_0000, 9'b1_1_0_0_0_0000,
                             9'b1_1_1_0_1_0001, 9'b1_1_0_0_1_0001};
      hold_reset();
      for (int i = 0; i < 4; i++) begin
         apply(qv[i], lv[i], 1'b0);
         checks++;
         if (obs !== ev[i]) begin
            errors++;
            $display("FAIL illegal_step[%0d]: got %b expected %b", i, obs, ev[i]);
         end
      end
   endtask

   task automatic test_l_mismatch();
      logic [8:0] exp_v;
      hold_reset();
      apply(2'd0, 1'b0, 1'b0);
      apply(2'd1, 1'b0, 1'b0);
      apply(2'd2, 1'b0, 1'b0);
      apply(2'd3, 1'b0, 1'b0);
      checks++;
      if (obs !== 9'b1_1_0_1_1_0001) begin
         errors++;
         $display("FAIL l_mismatch_first: got %b expected %b", obs, 9'b1_1_0_1_1_0001);
      end
      // Holding q=3 with L low keeps faulting; 20 events in total.
      for (int i = 2; i <= 20; i++) begin
         apply(2'd3, 1'b0, 1'b0);
         exp_v = {5'b1_1_0_1_1, (i > 15) ? 4'd15 : 4'(i)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL l_mismatch_sat[%0d]: got %b expected %b", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_clr_collision();
      logic [1:0] qv [3] = '{2'd3, 2'd3, 2'd3};
      logic       lv [3] = '{1'b0, 1'b1, 1'b1};
      logic       cv [3] = '{1'b1, 1'b1, 1'b0};
      logic [8:0] ev [3] = '{9'b1_1_0_1_1_0001, 9'b1_1_0_0_0_0000, 9'b1_1_0_0_0_0000};
      for (int i = 0; i < 3; i++) begin
         apply(qv[i], lv[i], cv[i]);
         checks++;
         if (obs !== ev[i]) begin
            errors++;
            $display("FAIL clr_collision[%0d]: got %b expected %b", i, obs, ev[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      apply(2'd0, 1'b0, 1'b0);
      checks++;
      if (obs !== 9'b1_1_0_0_0_0000) begin
         errors++;
         $display("FAIL mid_reset_pre: got %b expected %b", obs, 9'b1_1_0_0_0_0000);
      end
      apply(2'd2, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (obs !== 9'b0) begin
         errors++;
         $display("FAIL mid_reset_async: got %b expected %b", obs, 9'b0);
      end
      @(negedge clk);
      reset = 1'b1;
      apply(2'd2, 1'b1, 1'b0);
      checks++;
      if (obs !== 9'b0) begin
         errors++;
         $display("FAIL mid_reset_first_sample: got %b expected %b", obs, 9'b0);
      end
      apply(2'd3, 1'b1, 1'b0);
      checks++;
      if (obs !== 9'b1_1_0_0_0_0000) begin
         errors++;
         $display("FAIL mid_reset_relock: got %b expected %b", obs, 9'b1_1_0_0_0_0000);
      end
   endtask

   task automatic test_dirchg();
      logic [8:0] exp_rev;
`ifdef UPDOWN_DEC_DIRCHG_ERR_EN
      exp_rev = 9'b0_1_1_0_1_0001;
`else
      exp_rev = 9'b0_1_0_0_0_0000;
`endif
      hold_reset();
      apply(2'd1, 1'b0, 1'b0);
      apply(2'd2, 1'b0, 1'b0);
      checks++;
      if (obs !== 9'b1_1_0_0_0_0000) begin
         errors++;
         $display("FAIL dirchg_lock: got %b expected %b", obs, 9'b1_1_0_0_0_0000);
      end
      apply(2'd1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_rev) begin
         errors++;
         $display("FAIL dirchg_reverse: got %b expected %b", obs, exp_rev);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_illegal_step();
      test_l_mismatch();
      test_clr_collision();
      test_mid_reset();
      test_dirchg();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_count_decoder.md
Name: updown_count_decoder

Overview:
- Receiving end of the up/down counter's output interface.
- Samples the counter value q and its terminal flag L every clock, and recovers the count direction (the counter's x input) from successive values.
- Flags illegal steps and L values that disagree with the recovered direction.
- Sits downstream of the counter as a checker/decoder, so direction and errors are visible without access to x.

Parameters:
- WIDTH, 2, counter width in bits; must be >= 2.
- ERRCNT_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- q_in  input  WIDTH  counter value.
- l_in  input  1  counter terminal flag L.
- clr  input  1  synchronous clear of the sticky error and the error count.
- dir  output  1  recovered direction: 1 = up, 0 = down.
- dir_valid  output  1  dir has been established by at least one ±1 step.
- step_err  output  1  one-cycle pulse: illegal step detected.
- l_err  output  1  one-cycle pulse: L mismatch detected.
- err_sticky  output  1  set by any error, held until clr or reset.
- err_cnt  output  ERRCNT_W  saturating count of error events.

Behaviour:
- Reset (reset=0, asynchronous): state=EMPTY, q_prev=0, and every output is 0.
- States:
  - EMPTY: no previous sample. On the next clock, capture q_in into q_prev and go to PRIMED. No checks.
  - PRIMED: q_prev is valid but direction is unknown. Compute delta = (q_in - q_prev) mod 2^WIDTH.
    - delta=1: dir<=1, dir_valid<=1, go to LOCKED.
    - delta=2^WIDTH-1: dir<=0, dir_valid<=1, go to LOCKED.
    - delta=0: stay in PRIMED.
    - Any other delta: step_err pulse, stay in PRIMED.
  - LOCKED: apply the same delta rules. A ±1 step updates dir; a direction change is legal. delta=0 (hold) is legal and leaves dir unchanged. Any other delta raises step_err and leaves dir unchanged.
- q_prev<=q_in on every clock in every state.
- L check, in LOCKED only, using dir after the current step's update:
  - Expected L = (dir=1 and q_in=2^WIDTH-1) or (dir=0 and q_in=0).
  - l_in != expected raises l_err.
  - In PRIMED, l_in is not checked.
- Wrap-around: 3->0 (WIDTH=2) is a legal up step and 0->3 a legal down step; neither raises an error.
- Timing: step_err and l_err are registered and assert in the cycle after the clock edge that sampled the offending value, for exactly one cycle.
- Error accounting:
  - Both errors in the same sample count as one error event for err_cnt (increment by 1).
  - err_sticky<=1 on any error event.
  - err_cnt saturates at all-ones.
- clr:
  - clr=1 clears err_sticky and err_cnt on that edge.
  - If an error occurs in the same cycle, the error wins: err_sticky=1, err_cnt=1.
  - clr does not affect state, dir or dir_valid.
- Mid-operation reset: reset=0 at any time forces EMPTY immediately. After release, the first sample is never checked.
- Upstream counter reset: holding q at 0 while L is correct is legal. In LOCKED with dir=0, q_in=0 requires l_in=1.

Optional Feature:
- Macro: UPDOWN_DEC_DIRCHG_ERR_EN.
- Defined: in LOCKED, a ±1 step opposite to the current dir is an illegal direction reversal.
  - Raises step_err.
  - dir still updates to the new direction, so tracking continues.
  - A hold (delta=0) between the two steps does not excuse the reversal.
- Undefined: reversals are legal and only update dir, as described under Behaviour.

Test Plan:
- Reset then count up: reset=0 for 2 cycles, then release; q_in=0,1,2,3,0 with l_in=0,0,0,1,0 -> dir=1, dir_valid=1 from the 0->1 step, no errors, err_cnt=0.
- Count down: q_in=3,2,1,0,3 with l_in=0,0,0,1,0 -> dir=0, no errors; wrap 0->3 is legal.
- Illegal step: in LOCKED with dir=1, q_in 1->3 -> step_err pulses one cycle later, err_sticky=1, err_cnt=1, dir stays 1.
- L mismatch: in LOCKED with dir=1, q_in=3 and l_in=0 -> l_err pulse, err_cnt=1. Repeat the fault 20 times -> err_cnt saturates at 15.
- clr/error collision and mid-run reset: clr=1 in the same cycle as an error -> err_sticky=1, err_cnt=1. Pulse reset=0 mid-count -> all outputs 0 immediately, and the first post-release sample raises no error.
- With UPDOWN_DEC_DIRCHG_ERR_EN: q_in=1,2,1 -> step_err on the 2->1 step, dir=0. Without the macro, the same sequence gives no error.
